// File: rtl/ir_block_fetcher_if.sv
// Handshake/bus bundle between the IR block fetcher, its controller,
// program memory and the block consumer.
// Ports: i_req/i_req_addr/o_req_ack (controller request), i_flush (abort),
//        o_mem_rd/o_mem_addr/i_mem_valid/i_mem_data (program memory),
//        o_block/o_block_valid/i_block_ready (consumer), o_busy (status).
// master = environment side, slave = fetcher side.
interface ir_block_fetcher_if #(
    parameter int IR_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 8
);
    logic                            i_req;
    logic [ADDR_WIDTH-1:0]           i_req_addr;
    logic                            o_req_ack;
    logic                            i_flush;
    logic                            o_mem_rd;
    logic [ADDR_WIDTH-1:0]           o_mem_addr;
    logic                            i_mem_valid;
    logic [IR_WIDTH-1:0]             i_mem_data;
    logic [BLOCK_DEPTH*IR_WIDTH-1:0] o_block;
    logic                            o_block_valid;
    logic                            i_block_ready;
    logic                            o_busy;

    modport master (
        output i_req, i_req_addr, i_flush, i_mem_valid, i_mem_data,
        output i_block_ready,
        input  o_req_ack, o_mem_rd, o_mem_addr, o_block, o_block_valid,
        input  o_busy
    );

    modport slave (
        input  i_req, i_req_addr, i_flush, i_mem_valid, i_mem_data,
        input  i_block_ready,
        output o_req_ack, o_mem_rd, o_mem_addr, o_block, o_block_valid,
        output o_busy
    );
endinterface

// File: rtl/ir_block_fetcher.sv
// Fetches one block of BLOCK_DEPTH instruction words from program memory,
// one read at a time, and presents the assembled block to a consumer.
// Ports: clk, rst (sync, active-high), bus (ir_block_fetcher_if.slave).
// All bus outputs are registered; they are computed from the next state.
module ir_block_fetcher #(
    parameter int IR_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ir_block_fetcher_if.slave bus
);
    localparam int CW = $clog2(BLOCK_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [CW-1:0]                   r_count;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [BLOCK_DEPTH*IR_WIDTH-1:0] r_block;
    logic                            r_req_ack;
    logic                            r_mem_rd;
    logic [ADDR_WIDTH-1:0]           r_mem_addr;
    logic                            r_block_valid;
    logic                            r_busy;

    logic                            w_accept;
    logic                            w_capture;
    logic [ADDR_WIDTH-1:0]           w_mem_addr_d;
    logic                            w_mem_rd_d;
    logic                            w_block_valid_d;
    logic                            w_busy_d;

    // State register plus registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_base        <= '0;
            r_block       <= '0;
            r_req_ack     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_block_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_req_ack     <= w_accept;
            r_mem_rd      <= w_mem_rd_d;
            r_block_valid <= w_block_valid_d;
            r_busy        <= w_busy_d;
            if (w_mem_rd_d) begin
                r_mem_addr <= w_mem_addr_d;
            end
            if (w_accept) begin
                r_base  <= bus.i_req_addr;
                r_count <= '0;
            end
            if (w_capture) begin
                r_block[int'(r_count)*IR_WIDTH +: IR_WIDTH] <= bus.i_mem_data;
                if (r_count != LAST) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // Next-state logic; flush wins over every other input outside IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_req && !bus.i_flush) w_next = S_READ;
            end
            S_READ: begin
                w_next = bus.i_flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_flush) begin
                    // A read still in flight must be absorbed before IDLE.
                    w_next = bus.i_mem_valid ? S_IDLE : S_DRAIN;
                end else if (bus.i_mem_valid) begin
                    w_next = (r_count == LAST) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                if (bus.i_flush || bus.i_block_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.i_mem_valid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output/next-value logic feeding the output registers.
    always_comb begin
        w_accept  = (r_state == S_IDLE) && bus.i_req && !bus.i_flush;
        w_capture = (r_state == S_WAIT) && bus.i_mem_valid && !bus.i_flush;
        // Address of the next word: the new base on accept, else base+count+1.
        w_mem_addr_d = w_accept ? bus.i_req_addr
                     : r_base + ADDR_WIDTH'(r_count) + ADDR_WIDTH'(1);
        w_mem_rd_d      = (w_next == S_READ);
        w_block_valid_d = (w_next == S_DONE);
        w_busy_d        = (w_next != S_IDLE);
    end

    assign bus.o_req_ack     = r_req_ack;
    assign bus.o_mem_rd      = r_mem_rd;
    assign bus.o_mem_addr    = r_mem_addr;
    assign bus.o_block       = r_block;
    assign bus.o_block_valid = r_block_valid;
    assign bus.o_busy        = r_busy;
endmodule

// File: tb/tb_ir_block_fetcher.sv
// Scoreboard bench for ir_block_fetcher: read addresses and blocks are
// queued when a request is driven and checked when the DUT produces them.
module tb_ir_block_fetcher;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ir_block_fetcher_if bus ();

    ir_block_fetcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  addr_q[$];
    logic [63:0] blk_q[$];

    // Memory model state
    int         pend     = 0;
    int         dly      = 0;
    logic [7:0] paddr    = '0;
    int         mem_wait = 0;
    int         rd_cnt   = 0;
    int         vld_cnt  = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] blk(logic [7:0] b);
        logic [63:0] r;
        logic [7:0]  a;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = b + 8'(k);
            r[k*8 +: 8] = a ^ 8'h5A;
        end
        return r;
    endfunction

    // One clock: advance, then drive memory and monitor reads at edge+1.
    task automatic step();
        logic vld_now;
        @(posedge clk);
        #1;
        vld_now = 1'b0;
        if (pend != 0) begin
            if (dly == 0) begin
                vld_now = 1'b1;
                pend = 0;
            end else begin
                dly--;
            end
        end
        bus.i_mem_valid = vld_now;
        bus.i_mem_data  = vld_now ? (paddr ^ 8'h5A) : 8'h00;
        if (vld_now) vld_cnt++;
        if (bus.o_mem_rd) begin
            rd_cnt++;
            chk("one_outstanding", 64'(pend != 0 || vld_now), 64'd0);
            if (addr_q.size() == 0) begin
                chk("rd_unexpected", 64'd1, 64'd0);
            end else begin
                chk("mem_addr", 64'(bus.o_mem_addr), 64'(addr_q.pop_front()));
            end
            paddr = bus.o_mem_addr;
            pend  = 1;
            dly   = (mem_wait < 0) ? int'($urandom_range(5, 0)) : mem_wait;
        end
    endtask

    task automatic start_req(logic [7:0] a);
        for (int k = 0; k < 8; k++) addr_q.push_back(a + 8'(k));
        blk_q.push_back(blk(a));
        bus.i_req      = 1'b1;
        bus.i_req_addr = a;
        step();
        bus.i_req = 1'b0;
        chk("req_ack", 64'(bus.o_req_ack), 64'd1);
        chk("busy", 64'(bus.o_busy), 64'd1);
    endtask

    task automatic wait_done(bit spam);
        int n;
        n = 0;
        while (!bus.o_block_valid && n < 300) begin
            bus.i_req      = spam ? 1'($urandom_range(1, 0)) : 1'b0;
            bus.i_req_addr = 8'hA5;
            step();
            n++;
            chk("no_ack", 64'(bus.o_req_ack), 64'd0);
        end
        bus.i_req = 1'b0;
        if (!bus.o_block_valid) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept(int hold, bit spam);
        logic [63:0] e;
        e = (blk_q.size() != 0) ? blk_q[0] : 64'd0;
        for (int i = 0; i < hold; i++) begin
            bus.i_req = spam;
            step();
            chk("hold_valid", 64'(bus.o_block_valid), 64'd1);
            chk("hold_block", bus.o_block, e);
            chk("hold_no_ack", 64'(bus.o_req_ack), 64'd0);
        end
        bus.i_req = 1'b0;
        if (blk_q.size() == 0) begin
            chk("blk_unexpected", 64'd1, 64'd0);
        end else begin
            chk("block", bus.o_block, blk_q.pop_front());
        end
        bus.i_block_ready = 1'b1;
        step();
        bus.i_block_ready = 1'b0;
        chk("valid_drop", 64'(bus.o_block_valid), 64'd0);
        chk("idle_busy", 64'(bus.o_busy), 64'd0);
        chk("block_kept", bus.o_block, e);
    endtask

    initial begin
        int cyc;
        int rd0;
        int v0;
        logic [63:0] e;

        bus.i_req         = 1'b0;
        bus.i_req_addr    = '0;
        bus.i_flush       = 1'b0;
        bus.i_mem_valid   = 1'b0;
        bus.i_mem_data    = '0;
        bus.i_block_ready = 1'b0;

        rst = 1'b1;
        step();
        step();
        chk("rst_block", bus.o_block, 64'd0);
        chk("rst_valid", 64'(bus.o_block_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_ack", 64'(bus.o_req_ack), 64'd0);
        chk("rst_rd", 64'(bus.o_mem_rd), 64'd0);
        chk("rst_addr", 64'(bus.o_mem_addr), 64'd0);
        rst = 1'b0;

        // Zero-wait fetch and minimum latency
        mem_wait = 0;
        start_req(8'h10);
        cyc = 1;
        while (!bus.o_block_valid && cyc < 60) begin
            step();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'd17);
        accept(0, 1'b0);

        // Address wrap, random wait, consumer stall
        mem_wait = -1;
        rd0 = rd_cnt;
        v0  = vld_cnt;
        start_req(8'hFC);
        wait_done(1'b0);
        accept(10, 1'b0);
        chk("rd_count", 64'(rd_cnt - rd0), 64'd8);
        chk("vld_count", 64'(vld_cnt - v0), 64'd8);
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);

        // Requests outside IDLE are ignored
        start_req(8'h20);
        wait_done(1'b1);
        accept(4, 1'b1);

        // Flush in WAIT while word 4 is in flight -> DRAIN
        mem_wait = 0;
        rd0 = rd_cnt;
        start_req(8'h30);
        cyc = 0;
        while (rd_cnt - rd0 < 4 && cyc < 100) begin
            step();
            cyc++;
        end
        mem_wait = 4;
        while (rd_cnt - rd0 < 5 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        addr_q.delete();
        blk_q.delete();
        chk("drain_busy", 64'(bus.o_busy), 64'd1);
        chk("drain_rd", 64'(bus.o_mem_rd), 64'd0);
        cyc = 0;
        while (bus.o_busy && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain_exit", 64'(bus.o_busy), 64'd0);
        e = blk(8'h30);
        e[63:32] = blk(8'h20) >> 32;
        chk("drain_block", bus.o_block, e);
        chk("drain_valid", 64'(bus.o_block_valid), 64'd0);

        // Clean block after drain
        mem_wait = -1;
        start_req(8'h40);
        wait_done(1'b0);
        accept(2, 1'b0);

        // Flush in DONE beats ready
        start_req(8'h50);
        wait_done(1'b0);
        bus.i_flush       = 1'b1;
        bus.i_block_ready = 1'b1;
        step();
        bus.i_block_ready = 1'b0;
        blk_q.delete();
        chk("fdone_valid", 64'(bus.o_block_valid), 64'd0);
        chk("fdone_busy", 64'(bus.o_busy), 64'd0);
        chk("fdone_block", bus.o_block, blk(8'h50));

        // Flush in IDLE blocks a request
        bus.i_req      = 1'b1;
        bus.i_req_addr = 8'h77;
        step();
        bus.i_req   = 1'b0;
        bus.i_flush = 1'b0;
        chk("fidle_ack", 64'(bus.o_req_ack), 64'd0);
        chk("fidle_busy", 64'(bus.o_busy), 64'd0);

        // Flush in READ; the late return lands in IDLE and is ignored
        mem_wait = 0;
        start_req(8'h60);
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        addr_q.delete();
        blk_q.delete();
        chk("fread_busy", 64'(bus.o_busy), 64'd0);
        chk("fread_rd", 64'(bus.o_mem_rd), 64'd0);
        step();
        step();
        chk("fread_block", bus.o_block, blk(8'h50));

        // Reset in WAIT; stale return afterwards is ignored
        mem_wait = 3;
        start_req(8'h70);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        addr_q.delete();
        blk_q.delete();
        chk("rwait_block", bus.o_block, 64'd0);
        chk("rwait_valid", 64'(bus.o_block_valid), 64'd0);
        chk("rwait_busy", 64'(bus.o_busy), 64'd0);
        chk("rwait_rd", 64'(bus.o_mem_rd), 64'd0);
        chk("rwait_addr", 64'(bus.o_mem_addr), 64'd0);
        chk("rwait_ack", 64'(bus.o_req_ack), 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("stale_block", bus.o_block, 64'd0);
        chk("stale_busy", 64'(bus.o_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
